uart_rx: RTL



---
 rtl/uart_rx.sv | 131 +++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop line synchronizer, mid-bit start qualification,
// centre sampling, framing-error detection and a running byte checksum.
module uart_rx #(
    parameter int clocks_per_bit = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        SER_RX,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        rx_error,
    output logic        rx_busy,
    output logic [31:0] rx_sum
);

    localparam int TW = $clog2(clocks_per_bit);
    localparam logic [TW-1:0] HALF_M1 = TW'(clocks_per_bit / 2 - 1);
    localparam logic [TW-1:0] FULL_M1 = TW'(clocks_per_bit - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    sync_q;
    logic          rx_s;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_d;
    logic [31:0]   sum_d;
    logic          valid_d, error_d;

    // Both flops reset high so reset release never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= 2'b11;
        else        sync_q <= {sync_q[0], SER_RX};
    end

    assign rx_s    = sync_q[1];
    assign rx_busy = (state_q != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            rx_error  <= 1'b0;
            rx_sum    <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            rx_data   <= data_d;
            rx_valid  <= valid_d;
            rx_error  <= error_d;
            rx_sum    <= sum_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        data_d    = rx_data;
        sum_d     = rx_sum;
        valid_d   = 1'b0;
        error_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    timer_d = HALF_M1;
                end
            end
            START: begin
                if (timer_q == '0) begin
                    // Line back high at mid start bit: treat as a glitch.
                    if (rx_s) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = DATA;
                        timer_d   = FULL_M1;
                        bit_cnt_d = '0;
                    end
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            DATA: begin
                if (timer_q == '0) begin
                    shift_d   = {rx_s, shift_q[7:1]};
                    timer_d   = FULL_M1;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = STOP;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            STOP: begin
                if (timer_q == '0) begin
                    if (rx_s) begin
                        valid_d = 1'b1;
                        data_d  = shift_q;
                        sum_d   = rx_sum + {24'b0, shift_q};
                        state_d = IDLE;
                    end else begin
                        error_d = 1'b1;
                        state_d = BREAK;
                    end
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            BREAK: begin
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
